dpram_burst_master: RTL and testbench

//  Initiator for dual_port_syn: turns a write stream (valid/ready) into RAM writes at incrementing

---
 rtl/dpram_burst_master_pkg.sv | 8 +
 rtl/dpram_burst_master_if.sv | 36 +++
 rtl/dpram_burst_master_skid.sv | 36 +++
 rtl/dpram_burst_master.sv | 110 +++++++++++
 tb/tb_dpram_burst_master.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_burst_master_pkg.sv
// dpram_burst_pkg: engine states and default widths for dpram_burst_master
package dpram_burst_pkg;
  localparam int WI = 8;
  localparam int DEP = 16;
  localparam int ADD = 4;
  typedef enum logic {W_IDLE, W_RUN} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_state_t;
endpackage

// File: rtl/dpram_burst_master_if.sv
// dpram_burst_master_if: command, stream and RAM-port bundle between dpram_burst_master and its peers
interface dpram_burst_master_if
  import dpram_burst_pkg::*;
#(
  parameter int wi = WI,
  parameter int add = ADD
);
  logic wr_start;
  logic [add-1:0] wr_base;
  logic [add:0] wr_len;
  logic s_valid;
  logic [wi-1:0] s_data;
  logic s_ready;
  logic wr_done;
  logic rd_start;
  logic [add-1:0] rd_base;
  logic [add:0] rd_len;
  logic m_valid;
  logic [wi-1:0] m_data;
  logic m_ready;
  logic rd_done;
  logic wr;
  logic [add-1:0] wa;
  logic [wi-1:0] din;
  logic rd;
  logic [add-1:0] ra;
  logic [wi-1:0] dout;
  modport master (
    input wr_start, wr_base, wr_len, s_valid, s_data, rd_start, rd_base, rd_len, m_ready, dout,
    output s_ready, wr_done, m_valid, m_data, rd_done, wr, wa, din, rd, ra
  );
  modport slave (
    output wr_start, wr_base, wr_len, s_valid, s_data, rd_start, rd_base, rd_len, m_ready, dout,
    input s_ready, wr_done, m_valid, m_data, rd_done, wr, wa, din, rd, ra
  );
endinterface

// File: rtl/dpram_burst_master_skid.sv
// dpram_skid: 2-entry fall-through buffer for RAM read data with valid/ready output
module dpram_skid
  import dpram_burst_pkg::*;
#(
  parameter int wi = WI
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  input logic [wi-1:0] in_data,
  input logic out_ready,
  output logic out_valid,
  output logic [wi-1:0] out_data,
  output logic [1:0] used
);
  logic [wi-1:0] mem [2];
  logic rp, wp, push, take;
  always_comb begin
    out_valid = in_valid || used != 2'd0;
    out_data = used != 2'd0 ? mem[rp] : in_valid ? in_data : '0;
    take = out_valid && out_ready && used != 2'd0;
    push = in_valid && !(out_ready && used == 2'd0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      mem <= '{default: '0};
      rp <= 1'b0;
      wp <= 1'b0;
      used <= 2'd0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp <= wp ^ push;
      rp <= rp ^ take;
      used <= used + 2'(push) - 2'(take);
    end
endmodule

// File: rtl/dpram_burst_master.sv
// dpram_burst_master: dual_port_syn burst initiator; DPRAM_BURST_COLLISION_EN stalls same-address reads and adds collision_cnt
module dpram_burst_master
  import dpram_burst_pkg::*;
#(
  parameter int wi = WI,
  parameter int dep = DEP,
  parameter int add = ADD
) (
  input logic clk,
  input logic rst,
  dpram_burst_master_if.master bus
`ifdef DPRAM_BURST_COLLISION_EN
  ,
  output logic [add:0] collision_cnt
`endif
);
  wr_state_t w_st, w_nx;
  rd_state_t r_st, r_nx;
  logic [add-1:0] w_addr, r_addr;
  logic [add:0] w_rem, r_rem;
  logic beat, w_go, w_zero, w_last, r_go, r_zero, cap, credit, stall, issue, last, pop, z_done, m_valid;
  logic [1:0] used;
  logic [wi-1:0] m_data;
  always_comb begin
    w_go = w_st == W_IDLE && bus.wr_start;
    w_zero = w_go && bus.wr_len == '0;
    beat = w_st == W_RUN && bus.s_valid;
    w_last = beat && w_rem == (add+1)'(1);
    w_nx = w_go && !w_zero ? W_RUN : w_last ? W_IDLE : w_st;
    r_go = r_st == R_IDLE && bus.rd_start;
    r_zero = r_go && bus.rd_len == '0;
    pop = m_valid && bus.m_ready;
    credit = r_st == R_RUN && {1'b0, used} + 3'(bus.rd) + 3'(cap) - 3'(pop) < 3'd2;
`ifdef DPRAM_BURST_COLLISION_EN
    stall = beat && w_addr == r_addr;
`else
    stall = 1'b0;
`endif
    issue = credit && !stall;
    last = r_st == R_DRAIN && !bus.rd && {1'b0, used} + 3'(cap) == 3'd1 && pop;
    r_nx = r_go && !r_zero ? R_RUN : issue && r_rem == (add+1)'(1) ? R_DRAIN : last ? R_IDLE : r_st;
  end
  assign bus.s_ready = w_st == W_RUN;
  assign bus.m_valid = m_valid;
  assign bus.m_data = m_data;
  assign bus.rd_done = z_done || last;
  always_ff @(posedge clk) begin
    w_st <= rst ? W_IDLE : w_nx;
    r_st <= rst ? R_IDLE : r_nx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      w_addr <= '0;
      w_rem <= '0;
      bus.wr <= 1'b0;
      bus.wa <= '0;
      bus.din <= '0;
      bus.wr_done <= 1'b0;
    end else begin
      bus.wr <= beat;
      bus.wr_done <= w_zero || w_last;
      if (w_go) begin
        w_addr <= bus.wr_base;
        w_rem <= bus.wr_len;
      end
      if (beat) begin
        bus.wa <= w_addr;
        bus.din <= bus.s_data;
        w_addr <= w_addr == add'(dep - 1) ? '0 : w_addr + 1'b1;
        w_rem <= w_rem - 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_addr <= '0;
      r_rem <= '0;
      bus.rd <= 1'b0;
      bus.ra <= '0;
      cap <= 1'b0;
      z_done <= 1'b0;
    end else begin
      bus.rd <= issue;
      cap <= bus.rd;
      z_done <= r_zero;
      if (r_go) begin
        r_addr <= bus.rd_base;
        r_rem <= bus.rd_len;
      end
      if (issue) begin
        bus.ra <= r_addr;
        r_addr <= r_addr == add'(dep - 1) ? '0 : r_addr + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
`ifdef DPRAM_BURST_COLLISION_EN
  always_ff @(posedge clk)
    if (rst) collision_cnt <= '0;
    else if (credit && stall && collision_cnt != '1) collision_cnt <= collision_cnt + 1'b1;
`endif
  dpram_skid #(.wi(wi)) skid (
    .clk(clk),
    .rst(rst),
    .in_valid(cap),
    .in_data(bus.dout),
    .out_ready(bus.m_ready),
    .out_valid(m_valid),
    .out_data(m_data),
    .used(used)
  );
endmodule

// File: tb/tb_dpram_burst_master.sv
// tb_dpram_burst_master: randomized burst traffic against a queue-based reference model
module tb_dpram_burst_master;
  import dpram_burst_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dpram_burst_master_if bus ();
`ifdef DPRAM_BURST_COLLISION_EN
  logic [4:0] collision_cnt;
`endif
  dpram_burst_master dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DPRAM_BURST_COLLISION_EN
    ,
    .collision_cnt(collision_cnt)
`endif
  );
  localparam logic [7:0] INIT [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                                       8'h98, 8'ha9, 8'hba, 8'hcb, 8'hdc, 8'hed, 8'hfe, 8'h0f};
  logic [7:0] ram [16] = INIT;
  logic [7:0] shadow [16] = INIT;
  always @(posedge clk) begin
    if (bus.wr) ram[bus.wa] <= bus.din;
    if (bus.rd) bus.dout <= ram[bus.ra];
  end
  int total = 0;
  int bad = 0;
  logic [11:0] wq [$];
  logic [7:0] rq [$];
  logic [3:0] raq [$];
  int w_left = 0;
  int r_out = 0;
  bit wz_due = 0;
  bit rz_due = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("s_ready", 32'(bus.s_ready), 32'(w_left != 0));
      if (bus.wr) begin
        if (wq.size() == 0) flag("unexpected wr");
        else begin
          chk("wa", 32'(bus.wa), 32'(wq[0][11:8]));
          chk("din", 32'(bus.din), 32'(wq[0][7:0]));
          chk("wr_done", 32'(bus.wr_done), 32'(wq.size() == 1));
          void'(wq.pop_front());
        end
      end else chk("wr_done idle", 32'(bus.wr_done), 32'(wz_due));
      wz_due = 0;
      if (bus.rd) begin
        if (raq.size() == 0) flag("unexpected rd");
        else begin
          chk("ra", 32'(bus.ra), 32'(raq[0]));
          void'(raq.pop_front());
          r_out++;
        end
      end
      total++;
      if (r_out > 2) begin
        bad++;
        $display("FAIL outstanding: got %0d want <=2", r_out);
      end
      if (rq.size() == 0) chk("m_valid idle", 32'(bus.m_valid), 0);
      if (bus.m_valid && bus.m_ready) begin
        if (rq.size() == 0) flag("unexpected read word");
        else begin
          chk("m_data", 32'(bus.m_data), 32'(rq[0]));
          chk("rd_done", 32'(bus.rd_done), 32'(rq.size() == 1));
          void'(rq.pop_front());
          r_out--;
        end
      end else chk("rd_done idle", 32'(bus.rd_done), 32'(rz_due));
      rz_due = 0;
    end
  task automatic write_burst(input logic [3:0] base, input int len, input logic [7:0] data [$], input int gap);
    int cyc;
    bit hs;
    bus.wr_base = base;
    bus.wr_len = 5'(len);
    bus.wr_start = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_start = 1'b0;
    if (len == 0) wz_due = 1;
    for (int i = 0; i < len; i++) begin
      wq.push_back({4'(base + i), data[i]});
      shadow[4'(base + i)] = data[i];
    end
    w_left = len;
    cyc = 0;
    for (int i = 0; i < len;) begin
      bus.s_valid = $urandom_range(99) >= gap;
      bus.s_data = bus.s_valid ? data[i] : 8'($urandom);
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        i++;
        w_left--;
      end
      if (++cyc > 300) begin
        flag("write beat timeout");
        break;
      end
    end
    bus.s_valid = 1'b0;
    cyc = 0;
    while (wq.size() != 0 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (wq.size() != 0) flag("write drain timeout");
  endtask
  task automatic read_burst(input logic [3:0] base, input int len, input int mode);
    int cyc;
    bus.rd_base = base;
    bus.rd_len = 5'(len);
    bus.rd_start = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_start = 1'b0;
    if (len == 0) rz_due = 1;
    for (int i = 0; i < len; i++) begin
      rq.push_back(shadow[4'(base + i)]);
      raq.push_back(4'(base + i));
    end
    cyc = 0;
    while (rq.size() != 0 && cyc < 300) begin
      bus.m_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(1));
      @(posedge clk);
      #1;
      cyc++;
    end
    if (rq.size() != 0) flag("read timeout");
    bus.m_ready = 1'b1;
  endtask
  logic [7:0] lit [4] = '{8'ha1, 8'hb2, 8'hc3, 8'hd4};
  logic [7:0] d [$];
  logic [3:0] b;
  int n, m;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.wr_start = 0;
    bus.wr_base = 0;
    bus.wr_len = 0;
    bus.s_valid = 0;
    bus.s_data = 0;
    bus.rd_start = 0;
    bus.rd_base = 0;
    bus.rd_len = 0;
    bus.m_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset s_ready", 32'(bus.s_ready), 0);
    chk("reset wr", 32'(bus.wr), 0);
    chk("reset rd", 32'(bus.rd), 0);
    chk("reset m_valid", 32'(bus.m_valid), 0);
    chk("reset dones", 32'({bus.wr_done, bus.rd_done}), 0);
    @(posedge clk);
    #1;
    d = {8'ha1, 8'hb2, 8'hc3, 8'hd4};
    fork
      write_burst(4'd3, 4, d, 0);
      begin
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("t1 wr", 32'(bus.wr), 32'(k >= 1 && k <= 4));
          chk("t1 wr_done", 32'(bus.wr_done), 32'(k == 4));
          if (k >= 1 && k <= 4) begin
            chk("t1 wa", 32'(bus.wa), 32'(2 + k));
            chk("t1 din", 32'(bus.din), 32'(lit[k-1]));
          end
        end
      end
    join
    fork
      read_burst(4'd3, 4, 0);
      begin
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          chk("t2 m_valid", 32'(bus.m_valid), 32'(k >= 2 && k <= 5));
          chk("t2 rd_done", 32'(bus.rd_done), 32'(k == 5));
          if (k >= 2 && k <= 5) chk("t2 m_data", 32'(bus.m_data), 32'(lit[k-2]));
        end
      end
    join
    d = {8'h5a, 8'h6b, 8'h7c, 8'h8d};
    write_burst(4'd14, 4, d, 20);
    read_burst(4'd14, 4, 0);
    read_burst(4'd14, 6, 1);
    write_burst(4'd7, 0, d, 0);
    read_burst(4'd7, 0, 0);
    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fork
      write_burst(4'd0, 5, d, 30);
      read_burst(4'd8, 5, 2);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.wr_base = 4'd9;
        bus.wr_len = 5'd2;
        bus.wr_start = 1'b1;
        bus.rd_base = 4'd2;
        bus.rd_len = 5'd3;
        bus.rd_start = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_start = 1'b0;
        bus.rd_start = 1'b0;
      end
    join
    fork
      read_burst(4'd0, 8, 2);
      begin
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        rq.delete();
        raq.delete();
        r_out = 0;
        rz_due = 0;
        @(negedge clk);
        chk("t6 m_valid", 32'(bus.m_valid), 0);
        chk("t6 rd", 32'(bus.rd), 0);
        chk("t6 rd_done", 32'(bus.rd_done), 0);
      end
    join
    @(posedge clk);
    #1;
    read_burst(4'd5, 3, 0);
    for (int it = 0; it < 24; it++) begin
      b = 4'($urandom);
      d = {};
      if (it % 3 == 2) begin
        n = $urandom_range(8);
        m = $urandom_range(8);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        fork
          write_burst(b, n, d, 30);
          read_burst(4'(b + 8), m, 2);
        join
      end else begin
        n = $urandom_range(16);
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        write_burst(b, n, d, 30);
        read_burst(b, n, $urandom_range(2));
      end
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
